// File: rtl/fixedpoint_s_seq.sv
// Sequential signed fixed-point multiplier, Q(W-F).F operands and result.
// Radix-2 shift-add over W cycles, then round/saturate/wrap into W bits.
module fixedpoint_s_seq #(
   parameter int W = 8,
   parameter int F = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic         rnd_en,
   input  logic         sat_en,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_ovf
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam int PW = 2 * W + 1;
   localparam logic [PW-1:0] LIM_NEG = PW'(1) << (W - 1);
   localparam logic [PW-1:0] LIM_POS = LIM_NEG - PW'(1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state_reg, state_next;
   logic [W-1:0]    a_mag_reg, b_mag_reg;
   logic [2*W-1:0]  prod_reg;
   logic [CW-1:0]   cnt_reg;
   logic            sign_reg, rnd_reg, sat_reg;
   logic [W-1:0]    data_reg;
   logic            ovf_reg;

   logic            accept, last;
   logic [W-1:0]    a_abs, b_abs;
   logic [2*W-1:0]  partial, prod_next;
   logic            rbit;
   logic [PW-1:0]   m_val;
   logic            ovf_calc;
   logic [W-1:0]    wrap_val, sat_val, res_calc;

   assign accept = in_valid && (state_reg == IDLE);
   assign last   = (state_reg == CALC) && (cnt_reg == CW'(W - 1));

   // |-2^(W-1)| is exactly 2^(W-1) when read as an unsigned W-bit value
   assign a_abs = in_a[W-1] ? (~in_a + W'(1)) : in_a;
   assign b_abs = in_b[W-1] ? (~in_b + W'(1)) : in_b;

   assign partial   = b_mag_reg[cnt_reg] ? ({{W{1'b0}}, a_mag_reg} << cnt_reg) : '0;
   assign prod_next = prod_reg + partial;

   generate
      if (F > 0) begin : g_rnd
         assign rbit = rnd_reg && prod_next[F-1];
      end else begin : g_nornd
         assign rbit = 1'b0;
      end
   endgenerate

   assign m_val    = PW'(prod_next >> F) + {{(PW-1){1'b0}}, rbit};
   // Negative results may reach one step further than positive ones
   assign ovf_calc = sign_reg ? (m_val > LIM_NEG) : (m_val > LIM_POS);
   assign wrap_val = sign_reg ? (~m_val[W-1:0] + W'(1)) : m_val[W-1:0];
   assign sat_val  = sign_reg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
   assign res_calc = (ovf_calc && sat_reg) ? sat_val : wrap_val;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid) state_next = CALC;
         CALC:    if (last) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_reg == IDLE);
      out_valid = (state_reg == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_mag_reg <= '0;
         b_mag_reg <= '0;
         prod_reg  <= '0;
         cnt_reg   <= '0;
         sign_reg  <= 1'b0;
         rnd_reg   <= 1'b0;
         sat_reg   <= 1'b0;
         data_reg  <= '0;
         ovf_reg   <= 1'b0;
      end else if (accept) begin
         a_mag_reg <= a_abs;
         b_mag_reg <= b_abs;
         prod_reg  <= '0;
         cnt_reg   <= '0;
         sign_reg  <= in_a[W-1] ^ in_b[W-1];
         rnd_reg   <= rnd_en;
         sat_reg   <= sat_en;
      end else if (state_reg == CALC) begin
         prod_reg <= prod_next;
         cnt_reg  <= cnt_reg + CW'(1);
         if (last) begin
            data_reg <= res_calc;
            ovf_reg  <= ovf_calc;
         end
      end
   end

   assign out_data = data_reg;
   assign out_ovf  = ovf_reg;

endmodule

// File: doc/fixedpoint_s_seq.md
FIXEDPOINT_S_SEQ -- requirements
Module: fixedpoint_s_seq

Interface
REQ-001 Parameter W, default 8, meaning total operand/result width in bits, two's complement; legal range 4..32.
REQ-002 Parameter F, default 4, meaning fractional bits of operands and result (Q(W-F).F); legal range 0..W-1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand pair present.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 in_a  input  W  signed multiplicand, Q(W-F).F.
REQ-008 in_b  input  W  signed multiplier, Q(W-F).F.
REQ-009 rnd_en  input  1  1 = round half away from zero; 0 = truncate toward zero.
REQ-010 sat_en  input  1  1 = saturate on overflow; 0 = wrap to low W bits.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_data  output  W  signed product, Q(W-F).F.
REQ-014 out_ovf  output  1  rounded product was outside the representable range.

Function
REQ-015 States SHALL be IDLE, CALC, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 IDLE->CALC on rising edge with in_valid & in_ready; in_a, in_b, rnd_en, sat_en latched on that edge; later changes ignored.
REQ-017 CALC: sign = a_sign XOR b_sign; unsigned W-bit magnitudes |a|, |b| (|-2^(W-1)| = 2^(W-1) exactly); radix-2 shift-add, one multiplier bit per cycle, 2W-bit magnitude product P.
REQ-018 CALC->DONE after exactly W cycles; out_valid asserts W cycles after the accepting edge, out_data/out_ovf stable while in DONE.
REQ-019 Result magnitude M = P >> F, plus P[F-1] when rnd_en = 1 and F > 0; F = 0 makes rounding a no-op.
REQ-020 Signed result R = sign ? -M : M; range check against [-2^(W-1), 2^(W-1)-1]; a zero M yields R = 0 regardless of sign.
REQ-021 In range: out_data = R, out_ovf = 0.
REQ-022 Out of range, sat_en = 1: out_data = 2^(W-1)-1 if R > 0 else -2^(W-1); out_ovf = 1.
REQ-023 Out of range, sat_en = 0: out_data = R mod 2^W (low W bits); out_ovf = 1.
REQ-024 DONE->IDLE on rising edge with out_ready = 1; out_valid deasserts that edge; no new operand accepted on that same edge (min initiation interval W+2 cycles).
REQ-025 out_ready held low SHALL keep DONE indefinitely with outputs unchanged; in_valid ignored outside IDLE.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, in_ready = 1 (after release), out_valid = 0, out_data = 0, out_ovf = 0, and clear all datapath registers.
REQ-027 Reset asserted in CALC or DONE SHALL abandon the operation; no result is ever presented for it.
REQ-028 First acceptance possible on the first rising edge after rst_n deasserts.

Verification (W=8, F=4)
REQ-029 a=0x18 (1.5), b=0x20 (2.0), rnd_en=1, sat_en=1 -> out_data=0x30, out_ovf=0, out_valid 8 cycles after accept.
REQ-030 a=0x03, b=0x03: rnd_en=1 -> 0x01; rnd_en=0 -> 0x00; a=0xFD, b=0x03: rnd_en=1 -> 0xFF, rnd_en=0 -> 0x00; ovf=0 in all.
REQ-031 a=0x7F, b=0x7F: sat_en=1 -> 0x7F, ovf=1; sat_en=0 -> 0xF0, ovf=1; a=0x80, b=0x80, sat_en=1 -> 0x7F, ovf=1.
REQ-032 a=0x80, b=0x10 (-8.0 * 1.0) -> 0x80, ovf=0; a=0x80, b=0xF0 (-8.0 * -1.0), sat_en=1 -> 0x7F, ovf=1.
REQ-033 Backpressure: out_ready=0 for 20 cycles in DONE with in_valid=1 and changing operands -> outputs stable, in_ready=0, no acceptance; out_ready=1 -> IDLE next edge.
REQ-034 rst_n pulsed low at CALC cycle 4 -> out_valid=0, out_data=0 immediately; next accepted pair produces correct result with normal latency.
